mem_arbiter: RTL and testbench

- Shares the single multi-cycle main memory between the I-cache and D-cache miss handlers.
- Grants one requester at a time.
- Sequences an 8-beat block fill (issues 8 word reads, collects 8 returned words) or a single-word D-side write.
- Steers returned data and a beat index to the granted cache only.
- Sits between both caches' memory_request/memory_address/memory_data interfaces and the memory model.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arbiter_beat_counter.sv | 24 ++
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings and sizes for the I/D memory arbiter.
// Pure declarations: no latency or backpressure of its own.
package mem_arb_pkg;

  localparam int BEATS          = 8;
  localparam int BEAT_W         = $clog2(BEATS);
  localparam int BLOCK_OFS_BITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_beat_counter.sv
// Beat counter with clear/increment and terminal flag; count visible the cycle after inc.
// No backpressure: inc is obeyed every cycle, wraps after the last beat.
module beat_counter
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [BEAT_W-1:0] cnt,
  output logic              term
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign term = (cnt == BEAT_W'(BEATS - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin I/D arbiter for main memory: 8-beat pipelined fills or one-word D writes; grant+first issue 1 cycle after req.
// Requesters hold req until done; memory must accept one access per cycle and returns reads in order.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_grant,
  output logic [DATA_W-1:0] i_data,
  output logic              i_data_valid,
  output logic [BEAT_W-1:0] i_beat,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_grant,
  output logic [DATA_W-1:0] d_data,
  output logic              d_data_valid,
  output logic [BEAT_W-1:0] d_beat,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid
);

  state_t              state_q, state_d;
  owner_t              last_grant_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                iss_done_q;

  logic [BEAT_W-1:0]   iss_cnt, ret_cnt;
  logic                iss_term, ret_term;
  logic                any_req, pick_d, in_fill, own_d, fill_done;
  logic                unused_addr_bits;

  assign any_req = i_req | d_req;
  // On a tie, D wins unless it was the last one served.
  assign pick_d  = d_req & (~i_req | (last_grant_q == OWN_I));
  assign in_fill = (state_q == FILL);
  assign own_d   = (last_grant_q == OWN_D);

  // Low address bits never reach memory: fills are block aligned, writes word aligned.
  assign unused_addr_bits = ^{i_addr[BLOCK_OFS_BITS-1:0], d_addr[0]};

  beat_counter u_iss_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (~in_fill),
    .inc  (in_fill & ~iss_done_q),
    .cnt  (iss_cnt),
    .term (iss_term)
  );

  beat_counter u_ret_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (~in_fill),
    .inc  (in_fill & mem_rvalid),
    .cnt  (ret_cnt),
    .term (ret_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= OWN_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      iss_done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        last_grant_q <= pick_d ? OWN_D : OWN_I;
        wdata_q      <= d_wdata;
        if (!pick_d) begin
          addr_q <= {i_addr[ADDR_W-1:BLOCK_OFS_BITS], {BLOCK_OFS_BITS{1'b0}}};
        end else if (d_wr) begin
          addr_q <= {d_addr[ADDR_W-1:1], 1'b0};
        end else begin
          addr_q <= {d_addr[ADDR_W-1:BLOCK_OFS_BITS], {BLOCK_OFS_BITS{1'b0}}};
        end
      end
      if (!in_fill) begin
        iss_done_q <= 1'b0;
      end else if (iss_term) begin
        iss_done_q <= 1'b1;
      end
    end
  end

  // Completion keys on returned beats only, so a fast memory cannot end the fill early.
  assign fill_done = in_fill & mem_rvalid & ret_term;

  always_comb begin
    state_d      = state_q;
    i_grant      = 1'b0;
    i_data       = '0;
    i_data_valid = 1'b0;
    i_beat       = '0;
    i_done       = 1'b0;
    d_grant      = 1'b0;
    d_data       = '0;
    d_data_valid = 1'b0;
    d_beat       = '0;
    d_done       = 1'b0;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = (pick_d && d_wr) ? WRITE : FILL;
        end
      end

      FILL: begin
        mem_en = ~iss_done_q;
        if (!iss_done_q) begin
          mem_addr = {addr_q[ADDR_W-1:BLOCK_OFS_BITS], iss_cnt, 1'b0};
        end
        if (own_d) begin
          d_grant      = 1'b1;
          d_data_valid = mem_rvalid;
          d_data       = mem_rvalid ? mem_rdata : '0;
          d_beat       = ret_cnt;
          d_done       = fill_done;
        end else begin
          i_grant      = 1'b1;
          i_data_valid = mem_rvalid;
          i_data       = mem_rvalid ? mem_rdata : '0;
          i_beat       = ret_cnt;
          i_done       = fill_done;
        end
        if (fill_done) begin
          state_d = IDLE;
        end
      end

      WRITE: begin
        d_grant   = 1'b1;
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        d_done    = 1'b1;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle pipelined memory model (rdata = addr ^ 16'h5A5A).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_grant, i_data_valid, i_done;
  logic [15:0] i_data;
  logic [2:0]  i_beat;
  logic        d_grant, d_data_valid, d_done;
  logic [15:0] d_data;
  logic [2:0]  d_beat;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rvalid;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]  pv = 4'b0;
  logic [15:0] pa [4];
  logic        force_rv = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pv    <= {pv[2:0], mem_en & ~mem_wr};
    pa[0] <= mem_addr;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
    pa[3] <= pa[2];
  end

  assign mem_rvalid = pv[3] | force_rv;
  assign mem_rdata  = pa[3] ^ 16'h5A5A;

  logic [77:0] all_out;
  logic [21:0] i_out;
  assign i_out   = {i_grant, i_data, i_data_valid, i_beat, i_done};
  assign all_out = {i_out, d_grant, d_data, d_data_valid, d_beat, d_done,
                    mem_en, mem_wr, mem_addr, mem_wdata};

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_data(i_data),
    .i_data_valid(i_data_valid), .i_beat(i_beat), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_grant(d_grant), .d_data(d_data), .d_data_valid(d_data_valid),
    .d_beat(d_beat), .d_done(d_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; force_rv = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset;
    n_checks++;
    if (all_out !== 78'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    tick;
    n_checks++;
    if (all_out !== 78'd0) begin
      n_fail++; $display("FAIL post_reset_idle: got %h want 0", all_out);
    end
  endtask

  task automatic test_simultaneous;
    apply_reset;
    i_addr = 16'h0200; d_addr = 16'h0300; d_wr = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    for (int c = 1; c <= 39; c++) begin
      tick;
      if (c == 1 || c == 27) begin
        n_checks++;
        if ({i_grant, d_grant} !== 2'b01) begin
          n_fail++; $display("FAIL rr_d_grant c%0d: got i/d=%b want 01", c, {i_grant, d_grant});
        end
      end
      if (c == 13 || c == 26) begin
        n_checks++;
        if ({i_grant, d_grant, mem_en} !== 3'b000) begin
          n_fail++; $display("FAIL rr_idle_gap c%0d: got i/d/en=%b want 000", c, {i_grant, d_grant, mem_en});
        end
      end
      if (c == 14) begin
        n_checks++;
        if ({i_grant, d_grant, mem_addr} !== {2'b10, 16'h0200}) begin
          n_fail++; $display("FAIL rr_i_grant: got i/d=%b addr=%h want 10 0200", {i_grant, d_grant}, mem_addr);
        end
      end
      if (c == 12 || c == 25 || c == 38) begin
        n_checks++;
        if ({i_done, d_done} !== ((c == 25) ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL rr_done c%0d: got i/d done=%b", c, {i_done, d_done});
        end
      end
      if (c == 27) begin
        i_req = 1'b0; d_req = 1'b0;
      end
    end
    n_checks++;
    if (all_out !== 78'd0) begin
      n_fail++; $display("FAIL rr_final_idle: got %h want 0", all_out);
    end
  endtask

  task automatic test_lone_d_fill;
    logic [15:0] exp_addr;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h1A37;
    for (int c = 1; c <= 13; c++) begin
      tick;
      n_checks++;
      if (i_out !== 22'd0) begin
        n_fail++; $display("FAIL fill_i_quiet c%0d: got %h want 0", c, i_out);
      end
      n_checks++;
      if (d_grant !== (c <= 12)) begin
        n_fail++; $display("FAIL fill_grant c%0d: got %b", c, d_grant);
      end
      exp_addr = (c <= 8) ? 16'h1A30 + 16'(2 * (c - 1)) : 16'h0000;
      n_checks++;
      if ({mem_en, mem_wr, mem_addr} !== {(c <= 8), 1'b0, exp_addr}) begin
        n_fail++; $display("FAIL fill_issue c%0d: got en=%b wr=%b addr=%h want en=%b addr=%h",
                           c, mem_en, mem_wr, mem_addr, (c <= 8), exp_addr);
      end
      if (c >= 5 && c <= 12) begin
        n_checks++;
        if ({d_data_valid, d_beat, d_data} !== {1'b1, 3'(c - 5), (16'h1A30 + 16'(2 * (c - 5))) ^ 16'h5A5A}) begin
          n_fail++; $display("FAIL fill_return c%0d: got v=%b beat=%0d data=%h", c, d_data_valid, d_beat, d_data);
        end
      end else begin
        n_checks++;
        if (d_data_valid !== 1'b0) begin
          n_fail++; $display("FAIL fill_no_valid c%0d: got %b want 0", c, d_data_valid);
        end
      end
      n_checks++;
      if (d_done !== (c == 12)) begin
        n_fail++; $display("FAIL fill_done c%0d: got %b", c, d_done);
      end
      if (c == 12) d_req = 1'b0;
    end
  endtask

  task automatic test_d_write;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0043; d_wdata = 16'hBEEF;
    tick;
    n_checks++;
    if ({d_grant, i_grant, mem_en, mem_wr, mem_addr, mem_wdata, d_done} !== {4'b1011, 16'h0042, 16'hBEEF, 1'b1}) begin
      n_fail++; $display("FAIL write_cycle: got dg=%b ig=%b en=%b wr=%b addr=%h wdata=%h done=%b",
                         d_grant, i_grant, mem_en, mem_wr, mem_addr, mem_wdata, d_done);
    end
    d_req = 1'b0; d_wr = 1'b0; d_wdata = '0;
    tick;
    n_checks++;
    if (all_out !== 78'd0) begin
      n_fail++; $display("FAIL write_back_idle: got %h want 0", all_out);
    end
  endtask

  task automatic test_req_drop;
    int n_iss, n_val, n_done;
    n_iss = 0; n_val = 0; n_done = 0;
    i_req = 1'b1; i_addr = 16'h2345;
    for (int c = 1; c <= 13; c++) begin
      tick;
      if (c == 3) i_req = 1'b0;
      if (mem_en) begin
        n_checks++;
        if (mem_addr !== 16'h2340 + 16'(2 * n_iss)) begin
          n_fail++; $display("FAIL drop_issue_addr c%0d: got %h want %h", c, mem_addr, 16'h2340 + 16'(2 * n_iss));
        end
        n_iss++;
      end
      if (i_data_valid) begin
        n_checks++;
        if (i_beat !== 3'(n_val)) begin
          n_fail++; $display("FAIL drop_beat c%0d: got %0d want %0d", c, i_beat, n_val);
        end
        n_val++;
      end
      if (i_done) begin
        n_done++;
        n_checks++;
        if (c != 12) begin
          n_fail++; $display("FAIL drop_done_cycle: got %0d want 12", c);
        end
      end
    end
    n_checks++;
    if ({n_iss, n_val, n_done} !== {32'd8, 32'd8, 32'd1}) begin
      n_fail++; $display("FAIL drop_counts: got iss=%0d val=%0d done=%0d want 8 8 1", n_iss, n_val, n_done);
    end
    n_checks++;
    if ({i_grant, d_grant} !== 2'b00) begin
      n_fail++; $display("FAIL drop_no_regrant: got %b want 00", {i_grant, d_grant});
    end
  endtask

  task automatic test_reset_mid_fill;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h4000;
    for (int c = 1; c <= 6; c++) tick;
    rst = 1'b1; d_req = 1'b0;
    tick;
    n_checks++;
    if (all_out !== 78'd0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %h want 0", all_out);
    end
    rst = 1'b0;
    for (int c = 8; c <= 12; c++) begin
      tick;
      n_checks++;
      if (all_out !== 78'd0) begin
        n_fail++; $display("FAIL rstmid_stray c%0d: got %h want 0", c, all_out);
      end
      force_rv = (c == 10);
    end
    i_req = 1'b1; i_addr = 16'h0100;
    tick;
    n_checks++;
    if ({i_grant, d_grant, mem_en, mem_addr} !== {3'b101, 16'h0100}) begin
      n_fail++; $display("FAIL rstmid_regrant: got ig=%b dg=%b en=%b addr=%h", i_grant, d_grant, mem_en, mem_addr);
    end
    i_req = 1'b0;
    for (int c = 14; c <= 24; c++) tick;
    n_checks++;
    if (i_done !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_new_done: got %b want 1", i_done);
    end
    tick;
  endtask

  task automatic test_spurious;
    force_rv = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick;
      n_checks++;
      if ({i_data_valid, i_beat, i_done, d_data_valid, d_beat, d_done, mem_en} !== 10'd0) begin
        n_fail++; $display("FAIL spurious_valid k%0d: got iv=%b ib=%0d id=%b dv=%b db=%0d dd=%b en=%b",
                           k, i_data_valid, i_beat, i_done, d_data_valid, d_beat, d_done, mem_en);
      end
    end
    force_rv = 1'b0;
  endtask

  initial begin
    test_reset;
    test_simultaneous;
    test_lone_d_fill;
    test_d_write;
    test_req_drop;
    test_reset_mid_fill;
    test_spurious;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
